// File: rtl/car_motion.sv
// car_motion: integrates the 2-bit thrust command into a signed speed and a wall-clamped x position once per motion tick.
// Optional idle friction decay is compiled in when CAR_MOTION_FRICTION_EN is defined.
module car_motion #(
    parameter int TICK_DIV       = 833333,
    parameter int MAX_SPEED      = 7,
    parameter int POS_W          = 9,
    parameter int POS_MAX        = 319,
    parameter int POS_INIT       = 160,
    parameter int FRICTION_TICKS = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [1:0]       accel,
    input  logic             enable,
    output logic [3:0]       speed,
    output logic [POS_W-1:0] position,
    output logic             moving,
    output logic             update_pulse,
    output logic             hit_wall
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic signed [3:0] SPD_MAX = 4'(MAX_SPEED);
    localparam logic signed [POS_W+1:0] POS_HI = (POS_W+2)'(POS_MAX);
    localparam logic [POS_W-1:0] POS_RST = POS_W'(POS_INIT);
    localparam logic [POS_W-1:0] POS_TOP = POS_W'(POS_MAX);

    typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, COAST = 2'd2} state_t;

    function automatic logic signed [3:0] sat_step(input logic signed [3:0] s, input logic up);
        if (up) return (s >= SPD_MAX) ? SPD_MAX : s + 4'sd1;
        return (s <= -SPD_MAX) ? -SPD_MAX : s - 4'sd1;
    endfunction

    logic [CNT_W-1:0]        tick_cnt_q;
    logic                    pend_q;
    logic signed [3:0]       speed_q, speed_d;
    logic [POS_W-1:0]        pos_q;
    logic                    moving_q, update_q, hit_q;
    state_t                  state_q, state_d;
    logic                    tick, thrust;
    logic signed [POS_W+1:0] pos_sum;
    logic                    clamp_lo, clamp_hi;

`ifdef CAR_MOTION_FRICTION_EN
    localparam int IDLE_W = (FRICTION_TICKS > 1) ? $clog2(FRICTION_TICKS) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FRICTION_TICKS - 1);
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    function automatic logic signed [3:0] toward_zero(input logic signed [3:0] s);
        if (s > 4'sd0) return s - 4'sd1;
        if (s < 4'sd0) return s + 4'sd1;
        return s;
    endfunction
`endif

    assign tick   = (tick_cnt_q == TICK_LAST) && enable;
    assign thrust = (accel == 2'b10) || (accel == 2'b01);

    // Stage 1: speed and FSM next-state from the tick-edge accel sample
    always_comb begin
        speed_d = speed_q;
        state_d = state_q;
`ifdef CAR_MOTION_FRICTION_EN
        idle_cnt_d = '0;
`endif
        case (accel)
            2'b10:   speed_d = sat_step(speed_q, 1'b1);
            2'b01:   speed_d = sat_step(speed_q, 1'b0);
            default: begin
`ifdef CAR_MOTION_FRICTION_EN
                if (idle_cnt_q == IDLE_LAST) speed_d = toward_zero(speed_q);
                else                         idle_cnt_d = idle_cnt_q + 1'b1;
`endif
            end
        endcase
        case (state_q)
            IDLE:         state_d = thrust ? DRIVE : IDLE;
            DRIVE, COAST: state_d = thrust ? DRIVE : ((speed_d != 4'sd0) ? COAST : IDLE);
            default: begin
                state_d = IDLE;
                speed_d = 4'sd0;
            end
        endcase
    end

    // Stage 2: widened signed sum so both walls are detectable without wrap
    assign pos_sum  = $signed({2'b00, pos_q}) + $signed({{(POS_W-2){speed_q[3]}}, speed_q});
    assign clamp_lo = pos_sum < 0;
    assign clamp_hi = pos_sum > POS_HI;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            pend_q     <= 1'b0;
            speed_q    <= 4'sd0;
            pos_q      <= POS_RST;
            moving_q   <= 1'b0;
            update_q   <= 1'b0;
            hit_q      <= 1'b0;
            state_q    <= IDLE;
`ifdef CAR_MOTION_FRICTION_EN
            idle_cnt_q <= '0;
`endif
        end else begin
            update_q <= 1'b0;
            hit_q    <= 1'b0;
            if (enable) begin
                tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
                pend_q     <= tick;
                if (tick) begin
                    speed_q  <= speed_d;
                    moving_q <= (speed_d != 4'sd0);
                    state_q  <= state_d;
`ifdef CAR_MOTION_FRICTION_EN
                    idle_cnt_q <= idle_cnt_d;
`endif
                end else if (pend_q) begin
                    update_q <= 1'b1;
                    if (clamp_lo || clamp_hi) begin
                        pos_q    <= clamp_lo ? '0 : POS_TOP;
                        speed_q  <= 4'sd0;
                        moving_q <= 1'b0;
                        hit_q    <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        pos_q <= pos_sum[POS_W-1:0];
                    end
                end
            end
        end
    end

    assign speed        = speed_q;
    assign position     = pos_q;
    assign moving       = moving_q;
    assign update_pulse = update_q;
    assign hit_wall     = hit_q;
endmodule

// File: tb/tb_car_motion.sv
// Directed bench for car_motion with TICK_DIV=4; expectations follow CAR_MOTION_FRICTION_EN when defined.
module tb_car_motion;
    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [1:0] accel = 2'b00;
    logic [3:0] speed;
    logic [8:0] position;
    logic       moving, update_pulse, hit_wall;

    always #5 CLOCK_50 = ~CLOCK_50;

    car_motion #(.TICK_DIV(4)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .accel       (accel),
        .enable      (enable),
        .speed       (speed),
        .position    (position),
        .moving      (moving),
        .update_pulse(update_pulse),
        .hit_wall    (hit_wall)
    );

    int n_chk = 0;
    int n_fail = 0;
    int exp_spd, exp_pos, exp_wall, cyc, pulses, walls, p;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pulse(output int c);
        c = 0;
        do begin
            @(negedge CLOCK_50);
            c++;
        end while (update_pulse !== 1'b1 && c < 12);
        chk("pulse_seen", update_pulse, 1);
    endtask

    task automatic tick_chk(input logic [1:0] a, input int exp_cyc, input string tag);
        int c;
        accel = a;
        wait_pulse(c);
        chk($sformatf("%s_lat", tag), c, exp_cyc);
        chk($sformatf("%s_spd", tag), $signed(speed), exp_spd);
        chk($sformatf("%s_pos", tag), position, exp_pos);
        chk($sformatf("%s_mov", tag), moving, (exp_spd != 0) ? 1 : 0);
        chk($sformatf("%s_wall", tag), hit_wall, exp_wall);
    endtask

    initial begin
        repeat (3) @(negedge CLOCK_50);
        chk("rst_spd", $signed(speed), 0);
        chk("rst_pos", position, 160);
        chk("rst_mov", moving, 0);
        chk("rst_upd", update_pulse, 0);
        chk("rst_wall", hit_wall, 0);
        chk("rst_state", dut.state_q, 0);
        reset = 1'b1;

        exp_spd = 0; exp_pos = 160; exp_wall = 0;
        tick_chk(2'b00, 5, "boot");
        tick_chk(2'b00, 4, "idle");

        for (int i = 0; i < 10; i++) begin
            exp_spd = (exp_spd < 7) ? exp_spd + 1 : 7;
            exp_pos += exp_spd;
            tick_chk(2'b10, 4, "fwd");
        end
        chk("fwd10_pos", position, 209);
        chk("fwd10_spd", $signed(speed), 7);
        for (int i = 0; i < 15; i++) begin
            exp_pos += 7;
            tick_chk(2'b10, 4, "cruise");
        end
        chk("cruise_pos", position, 314);

        exp_spd = 0; exp_pos = 319; exp_wall = 1;
        tick_chk(2'b10, 4, "clampR");
        chk("clampR_state", dut.state_q, 0);
        @(negedge CLOCK_50);
        chk("clampR_wall_drop", hit_wall, 0);
        chk("clampR_upd_drop", update_pulse, 0);
        tick_chk(2'b10, 3, "clampR2");
        exp_wall = 0;

        for (int i = 0; i < 10; i++) begin
            exp_spd = (exp_spd > -7) ? exp_spd - 1 : -7;
            exp_pos += exp_spd;
            tick_chk(2'b01, 4, "back");
        end
        chk("back_pos", position, 270);
        for (int i = 0; i < 10; i++) begin
            exp_spd = (exp_spd < 7) ? exp_spd + 1 : 7;
            exp_pos += exp_spd;
            tick_chk(2'b10, 4, "brakeF");
        end
        chk("brakeF_pos", position, 255);
        chk("brakeF_spd", $signed(speed), 3);

        for (int i = 1; i <= 12; i++) begin
`ifdef CAR_MOTION_FRICTION_EN
            if (i % 4 == 0) exp_spd--;
`endif
            exp_pos += exp_spd;
            tick_chk(2'b00, 4, "coast");
        end
`ifdef CAR_MOTION_FRICTION_EN
        chk("fric_pos", position, 276);
        chk("fric_state", dut.state_q, 0);
`else
        chk("fric_pos", position, 291);
        chk("fric_state", dut.state_q, 2);
`endif

        exp_spd++; exp_pos += exp_spd;
        tick_chk(2'b10, 4, "prefrz");
        enable = 1'b0;
        pulses = 0; walls = 0;
        repeat (20) begin
            @(negedge CLOCK_50);
            pulses += int'(update_pulse);
            walls += int'(hit_wall);
        end
        chk("frz_pulses", pulses, 0);
        chk("frz_walls", walls, 0);
        chk("frz_spd", $signed(speed), exp_spd);
        chk("frz_pos", position, exp_pos);
        enable = 1'b1;
        exp_spd++; exp_pos += exp_spd;
        tick_chk(2'b10, 4, "thaw");

        repeat (3) @(negedge CLOCK_50);
        chk("s1_spd", $signed(speed), exp_spd + 1);
        chk("s1_pos", position, exp_pos);
        chk("s1_upd", update_pulse, 0);
        reset = 1'b0;
        @(negedge CLOCK_50);
        chk("midrst_upd", update_pulse, 0);
        chk("midrst_pos", position, 160);
        chk("midrst_spd", $signed(speed), 0);
        chk("midrst_mov", moving, 0);
        chk("midrst_wall", hit_wall, 0);
        chk("midrst_state", dut.state_q, 0);
        @(negedge CLOCK_50);
        chk("midrst_upd2", update_pulse, 0);
        reset = 1'b1;

        exp_spd = 1; exp_pos = 161; exp_wall = 0;
        tick_chk(2'b10, 5, "reboot");
        accel = 2'b01;
        @(negedge CLOCK_50);
        exp_spd = 2; exp_pos = 163;
        tick_chk(2'b10, 3, "glitch");

        for (int i = 0; i < 4; i++) begin
            exp_spd--;
            exp_pos += exp_spd;
            tick_chk(2'b01, 4, "brakeR");
            chk("brakeR_state", dut.state_q, 1);
        end
        chk("brakeR_pos", position, 161);

        walls = 0;
        for (int i = 0; i < 27; i++) begin
            exp_spd = (exp_spd > -7) ? exp_spd - 1 : -7;
            p = exp_pos + exp_spd;
            exp_wall = 0;
            if (p < 0) begin
                exp_pos = 0; exp_spd = 0; exp_wall = 1;
            end else begin
                exp_pos = p;
            end
            tick_chk(2'b01, 4, "left");
            walls += int'(hit_wall);
        end
        chk("left_walls", walls, 3);
        chk("left_pos", position, 0);
        chk("left_state", dut.state_q, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
